cu_phase_seq: RTL and testbench
===============================

Name: cu_phase_seq

Overview:
- Multicycle phase sequencer and instruction-class decoder; the stage directly upstream of the control-signal unit.
- Generates one-hot phase strobes P0–P4 plus idle/halt strobe P.
- Supplies the ALU function code Func and the R-type/add decode strobes OP00 and IRFunc22 that the control unit ANDs with the phases.
- Per-opcode phase length, memory-wait stalls, overflow abort, illegal-opcode halt and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- ADD_FUNC, 6'b100000, IRFunc code of add (ALU add)
- SUB_FUNC, 6'b100010, IRFunc code of sub (ALU subtract)

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  reset, synchronous, active-high
- Op  input  6  IR[31:26]; valid from P1 until the end of the next P0
- IRFunc  input  6  IR[5:0]; same validity as Op
- OV  input  1  ALU overflow flag, sampled only in P2
- mem_rdy  input  1  memory access complete this cycle
- P0, P1, P2, P3, P4  output  1 each  one-hot phase strobes
- P  output  1  idle/halt strobe
- Func  output  6  ALU function code
- OP00  output  1  Op==6'b000000
- IRFunc22  output  1  IRFunc==ADD_FUNC
- ov_abort  output  1  one-cycle pulse: instruction aborted on overflow
- illegal  output  1  sticky: unknown opcode decoded
- instr_cnt  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- clr is synchronous, active-high, and wins over every other input, including mid-instruction or during a stall.
- Reset values: state=IDLE, P=1, P0..P4=0, ov_abort=0, illegal=0, instr_cnt=0.
- States: IDLE, S0..S4, HALT. Exactly one of P, P0..P4 is high every cycle; P is high in IDLE and HALT. All strobes are registered state decodes.
- IDLE: lasts one cycle after clr deasserts, then S0.
- S0 (fetch): holds while mem_rdy=0; on mem_rdy=1 goes to S1.
- S1 (decode):
  - known opcode → S2;
  - unknown opcode → HALT, illegal←1.
- Known opcodes and phase sequences:
  - R-type 000000: S0-S1-S2-S3-S4
  - lw 100011: S0-S1-S2-S3-S4
  - addi 001000: S0-S1-S2-S3-S4
  - sw 101011: S0-S1-S2-S3
  - beq 000100: S0-S1-S2
  - j 000010: S0-S1-S2
- S2:
  - beq/j → S0 (retire);
  - R-type with IRFunc∈{ADD_FUNC,SUB_FUNC}, or addi, with OV=1 → S0, ov_abort=1 for exactly the next cycle (the first S0 cycle), no retire;
  - otherwise → S3.
- OV is ignored outside S2 and for non-trapping instructions.
- S3:
  - lw/sw hold while mem_rdy=0;
  - sw with mem_rdy=1 → S0 (retire);
  - lw with mem_rdy=1 → S4;
  - R-type/addi → S4 unconditionally (mem_rdy ignored).
- S4: → S0 (retire).
- Retire: instr_cnt+1 in the cycle the transition to S0 is taken. Wraps all-ones→0 silently. Abort does not increment.
- HALT: absorbing; only clr exits. instr_cnt frozen.
- Func (combinational from Op/IRFunc, all states):
  - R-type → IRFunc;
  - lw/sw/addi → ADD_FUNC;
  - beq → SUB_FUNC;
  - otherwise 6'b000000.
- OP00 and IRFunc22 are combinational decodes of the inputs, independent of state.
- Stall cycles do not advance any state or counter.

Test Plan:
- clr=1 for 2 cycles, then 0, mem_rdy=1, Op=0, IRFunc=100000, OV=0 → P=1 for 1 cycle after release; then P0,P1,P2,P3,P4 each exactly 1 cycle; instr_cnt=1 on the cycle after P4; Func=100000, OP00=1, IRFunc22=1.
- lw (Op=100011) with mem_rdy=0 for 3 cycles in P0 and 2 cycles in P3 → P0 high 4 cycles, P3 high 3 cycles, total 10 cycles to retire; Func=100000.
- R-type sub (IRFunc=100010) with OV=1 during P2 → next cycle P0=1 and ov_abort=1 (one cycle only); P3 never asserted; instr_cnt unchanged. Same with OV=1 on beq → no abort, retires after P2.
- Op=111111 at P1 → P=1, illegal=1 from the next cycle, held for 20 cycles despite mem_rdy toggling; clr → IDLE, illegal=0.
- Preload via 65535 back-to-back beq (3 cycles each, mem_rdy=1) → instr_cnt=16'hFFFF, then one more retire → 0.
- clr asserted during a P3 stall of sw → next cycle P=1, all P0..P4=0, instr_cnt=0.

Source files
------------

// File: rtl/cu_phase_seq.sv
// cu_phase_seq: multicycle phase sequencer and instruction-class decoder
//   in : clk, clr (sync, active-high), Op/IRFunc (IR fields), OV (ALU overflow), mem_rdy
//   out: P0..P4 one-hot phases, P idle/halt, Func ALU code, OP00/IRFunc22 decodes,
//        ov_abort pulse, illegal (sticky), instr_cnt retired-instruction counter
module cu_phase_seq #(
  parameter int          CNT_W    = 16,
  parameter logic [5:0]  ADD_FUNC = 6'b100000,
  parameter logic [5:0]  SUB_FUNC = 6'b100010
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       Op,
  input  logic [5:0]       IRFunc,
  input  logic             OV,
  input  logic             mem_rdy,
  output logic             P0,
  output logic             P1,
  output logic             P2,
  output logic             P3,
  output logic             P4,
  output logic             P,
  output logic [5:0]       Func,
  output logic             OP00,
  output logic             IRFunc22,
  output logic             ov_abort,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4, HALT} state_t;
  state_t r_state, w_next;
  logic [5:0] r_ph;
  logic r_ov_abort, r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic w_rt, w_lw, w_sw, w_ad, w_beq, w_j, w_br, w_mem, w_known, w_trap, w_abort, w_retire;
  assign w_rt    = Op == 6'b000000;
  assign w_lw    = Op == 6'b100011;
  assign w_sw    = Op == 6'b101011;
  assign w_ad    = Op == 6'b001000;
  assign w_beq   = Op == 6'b000100;
  assign w_j     = Op == 6'b000010;
  assign w_br    = w_beq | w_j;
  assign w_mem   = w_lw | w_sw;
  assign w_known = w_rt | w_mem | w_ad | w_br;
  // only add/sub R-types and addi can overflow-trap
  assign w_trap  = (w_rt & (IRFunc == ADD_FUNC | IRFunc == SUB_FUNC)) | w_ad;
  assign w_abort = r_state == S2 & ~w_br & w_trap & OV;
  assign w_retire = r_state == S4 | (r_state == S2 & w_br) | (r_state == S3 & w_sw & mem_rdy);
  always_comb begin
    w_next = r_state == IDLE ? S0 :
             r_state == S0   ? (mem_rdy ? S1 : S0) :
             r_state == S1   ? (w_known ? S2 : HALT) :
             r_state == S2   ? ((w_br | (w_trap & OV)) ? S0 : S3) :
             r_state == S3   ? (!w_mem ? S4 : !mem_rdy ? S3 : w_sw ? S0 : S4) :
             r_state == S4   ? S0 : HALT;
  end
  // strobes are registered alongside the state so they come straight from flops
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_ph       <= 6'b100000;
      r_ov_abort <= 1'b0;
      r_illegal  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_next;
      r_ph       <= {w_next == IDLE | w_next == HALT, w_next == S4, w_next == S3,
                     w_next == S2, w_next == S1, w_next == S0};
      r_ov_abort <= w_abort;
      r_illegal  <= r_illegal | (r_state == S1 & ~w_known);
      r_cnt      <= r_cnt + CNT_W'(w_retire);
    end
  end
  assign {P, P4, P3, P2, P1, P0} = r_ph;
  assign ov_abort  = r_ov_abort;
  assign illegal   = r_illegal;
  assign instr_cnt = r_cnt;
  assign Func      = w_rt ? IRFunc : (w_mem | w_ad) ? ADD_FUNC : w_beq ? SUB_FUNC : 6'b000000;
  assign OP00      = w_rt;
  assign IRFunc22  = IRFunc == ADD_FUNC;
endmodule

// File: tb/tb_cu_phase_seq.sv
// tb_cu_phase_seq: instruction-level reference model driving and checking cu_phase_seq each cycle
module tb_cu_phase_seq;
  localparam int W = 8;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010;
  logic clk = 0, clr = 1, OV = 0, mem_rdy = 0;
  logic [5:0] Op = 0, IRFunc = 0, n_op = 0, n_fn = 0;
  logic P0, P1, P2, P3, P4, P, OP00, IRFunc22, ov_abort, illegal;
  logic [5:0] Func;
  logic [W-1:0] instr_cnt;
  int checks = 0, passed = 0, cyc = 0;
  logic [W-1:0] m_cnt = 0;
  logic m_ill = 0, m_abort = 0;
  logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};

  cu_phase_seq #(.CNT_W(W)) dut (
    .clk(clk), .clr(clr), .Op(Op), .IRFunc(IRFunc), .OV(OV), .mem_rdy(mem_rdy),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P(P), .Func(Func),
    .OP00(OP00), .IRFunc22(IRFunc22), .ov_abort(ov_abort), .illegal(illegal),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [5:0] func_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return fn;
    if (op == 6'b100011 || op == 6'b101011 || op == 6'b001000) return ADD;
    if (op == 6'b000100) return SUB;
    return 6'b000000;
  endfunction

  // one clock: drive this cycle's inputs, then check the phase the model expects (5 = P)
  task automatic step(input int ph, input logic rdy, input logic ov, input logic c);
    @(posedge clk);
    #1;
    clr = c; mem_rdy = rdy; OV = ov; Op = n_op; IRFunc = n_fn;
    cyc++;
    @(negedge clk);
    chk("phase", {26'd0, P, P4, P3, P2, P1, P0}, 32'(1 << ph));
    chk("ov_abort", ov_abort, m_abort);
    chk("illegal", illegal, m_ill);
    chk("instr_cnt", instr_cnt, m_cnt);
    chk("Func", Func, func_of(Op, IRFunc));
    chk("OP00", OP00, Op == 6'b000000);
    chk("IRFunc22", IRFunc22, IRFunc == ADD);
    m_abort = 0;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic reset_model();
    m_cnt = 0; m_ill = 0; m_abort = 0;
  endtask

  // one instruction: s0/s3 are memory-wait cycles, kill asserts clr on the last P3 wait
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                       input int s0, input int s3, input bit kill = 0);
    bit rt = op == 6'b000000, lw = op == 6'b100011, sw = op == 6'b101011;
    bit ad = op == 6'b001000, br = op == 6'b000100 || op == 6'b000010;
    bit trap = (rt && (fn == ADD || fn == SUB)) || ad;
    n_op = op; n_fn = fn;
    for (int i = 0; i < s0; i++) step(0, 0, rb(), 0);
    step(0, 1, rb(), 0);
    step(1, rb(), rb(), 0);
    if (!(rt || lw || sw || ad || br)) begin
      m_ill = 1;
      return;
    end
    step(2, rb(), ov, 0);
    if (br) begin m_cnt++; return; end
    if (trap && ov) begin m_abort = 1; return; end
    if (lw || sw) begin
      for (int i = 0; i < s3; i++) begin
        if (kill && i == s3 - 1) begin
          step(3, 0, rb(), 1);
          reset_model();
          step(5, rb(), rb(), 0);
          return;
        end
        step(3, 0, rb(), 0);
      end
      step(3, 1, rb(), 0);
      if (sw) begin m_cnt++; return; end
    end else step(3, rb(), rb(), 0);
    step(4, rb(), rb(), 0);
    m_cnt++;
  endtask

  initial begin
    int t;
    step(5, 0, 0, 1);
    step(5, 0, 0, 1);
    step(5, 1, 0, 0);
    t = cyc;
    instr(6'b000000, ADD, 0, 0, 0);
    chk("lit_rtype_cycles", cyc - t, 5);
    chk("lit_cnt_after_add", m_cnt, 1);
    t = cyc;
    instr(6'b100011, 6'($urandom), 0, 3, 2);
    chk("lit_lw_cycles", cyc - t, 10);
    instr(6'b000000, SUB, 1, 0, 0);
    chk("lit_abort_pending", m_abort, 1);
    chk("lit_cnt_no_retire", m_cnt, 2);
    instr(6'b000100, 6'($urandom), 1, 0, 0);
    chk("lit_beq_ov_retire", m_cnt, 3);
    for (int k = 0; k < 300; k++) begin
      logic [5:0] fn;
      int sel = $urandom_range(2);
      fn = sel == 0 ? ADD : sel == 1 ? SUB : 6'($urandom);
      instr(ops[$urandom_range(5)], fn, rb(), $urandom_range(3), $urandom_range(3));
    end
    instr(6'b101011, 6'($urandom), 0, 1, 3, 1);
    chk("lit_cnt_after_kill", m_cnt, 0);
    for (int k = 0; k < 255; k++) instr(6'b000100, 6'($urandom), rb(), 0, 0);
    chk("lit_cnt_full", m_cnt, 8'hFF);
    instr(6'b000010, 6'($urandom), rb(), 0, 0);
    chk("lit_cnt_wrap", m_cnt, 0);
    instr(6'b000000, ADD, 0, 0, 0);
    instr(6'b111111, 6'($urandom), rb(), 1, 0);
    for (int k = 0; k < 20; k++) step(5, rb(), rb(), 0);
    step(5, rb(), rb(), 1);
    reset_model();
    step(5, 1, 0, 0);
    instr(6'b001000, 6'($urandom), 1, 0, 0);
    instr(6'b000000, 6'b100100, 1, 2, 0);
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
